mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATABITS, 32, data word width.
REQ-002 Parameter ADDRBITS, 32, byte-address width of the memory port.
REQ-003 Parameter MEMADDRBITS, 9, word-index width of backing store (2**MEMADDRBITS words).
REQ-004 Parameter RD_LATENCY, 1, cycles from accepted read request to first data beat; legal range 1..15.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 mem_addr  input  ADDRBITS  byte address; word index = mem_addr[MEMADDRBITS+1:2], other bits ignored.
REQ-008 mem_in  input  DATABITS  write data from requester.
REQ-009 mem_out  output  DATABITS  read data to requester.
REQ-010 mem_out_valid  output  1  mem_out holds a valid read beat this cycle.
REQ-011 mem_rdreq  input  1  read burst request, level.
REQ-012 mem_wrreq  input  1  write beat, one word per cycle.
REQ-013 mem_burstlen  input  16  read burst length in words; 0 treated as 1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_collision  output  1  sticky flag: write beat arrived outside IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LAT, BURST, DONE.
REQ-017 In IDLE with mem_wrreq=1, mem_in SHALL be written to word index of mem_addr on that edge; FSM stays IDLE.
REQ-018 In IDLE with mem_rdreq=1 and mem_wrreq=0, start address and burst length SHALL be latched and FSM SHALL enter LAT (or BURST directly when RD_LATENCY=1).
REQ-019 Simultaneous mem_rdreq and mem_wrreq in IDLE: write SHALL win; read not started that cycle.
REQ-020 LAT SHALL count RD_LATENCY-1 cycles, then enter BURST.
REQ-021 Request sampled at edge N SHALL give first mem_out_valid=1 in the cycle after edge N+RD_LATENCY.
REQ-022 BURST SHALL output exactly latched-burstlen consecutive beats, mem_out_valid=1 each, no gaps.
REQ-023 Word index SHALL increment by 1 per beat, wrapping modulo 2**MEMADDRBITS.
REQ-024 After last beat FSM SHALL enter DONE; mem_out_valid=0.
REQ-025 DONE SHALL return to IDLE on first cycle mem_rdreq=0; held mem_rdreq SHALL NOT start a second burst.
REQ-026 Changes of mem_addr, mem_burstlen, mem_rdreq during LAT/BURST SHALL be ignored.
REQ-027 mem_wrreq outside IDLE SHALL NOT write memory and SHALL set err_collision.
REQ-028 mem_out SHALL be registered from the backing store; value when mem_out_valid=0 is don't-care.
REQ-029 Burst length counter SHALL be 16 bits; burstlen 65535 SHALL complete without overflow.

Reset
REQ-030 reset_n=0 SHALL immediately force FSM=IDLE, mem_out_valid=0, busy=0, err_collision=0, mem_out=0, counters=0.
REQ-031 Reset mid-burst SHALL abort the burst; no further beats after release.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 State encodings and default parameter values SHALL live in a shared package used by cache-side blocks.
REQ-034 Backing store SHALL be one sub-module, resp_sram: synchronous write, registered read, single port.
REQ-035 Target size 120-400 lines RTL; no other sub-modules.

Verification
REQ-036 Write 0fff0001 to 00000080, then rdreq at 00000080 burstlen 1, RD_LATENCY=1 -> one beat 0fff0001 one cycle after request.
REQ-037 Write 0fff0001..0fff0008 to 00000080..0000009c, read burstlen 8 -> eight consecutive beats 0fff0001..0fff0008, then mem_out_valid=0, busy until rdreq drops.
REQ-038 RD_LATENCY=4, burstlen 2 at 000007fc (MEMADDRBITS=9) -> first beat 4 cycles after request, second beat from index 0 (wrap).
REQ-039 rdreq and wrreq together in IDLE at 00000100 data 22222222 -> written, no burst; next cycle read returns 22222222.
REQ-040 wrreq during BURST -> memory unchanged, err_collision=1 until reset.
REQ-041 reset_n low at beat 3 of burstlen 8 -> mem_out_valid=0 immediately, busy=0, no beats after release.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared state encodings and default parameter values for the memory responder
// and the cache-side blocks that talk to it.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LAT   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } resp_state_e;

  localparam int unsigned DEF_DATABITS    = 32;
  localparam int unsigned DEF_ADDRBITS    = 32;
  localparam int unsigned DEF_MEMADDRBITS = 9;
  localparam int unsigned DEF_RD_LATENCY  = 1;
  localparam int unsigned BURSTLEN_BITS   = 16;
  localparam int unsigned LAT_BITS        = 4;

  // A zero-length burst request still returns one word.
  function automatic logic [BURSTLEN_BITS-1:0] eff_burstlen(input logic [BURSTLEN_BITS-1:0] len);
    return (len == '0) ? BURSTLEN_BITS'(1) : len;
  endfunction

endpackage

// File: rtl/resp_sram.sv
// Single-port backing store: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module resp_sram #(
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned MEMADDRBITS = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic                   re,
  input  logic [MEMADDRBITS-1:0] addr,
  input  logic [DATABITS-1:0]    wdata,
  output logic [DATABITS-1:0]    rdata
);

  logic [DATABITS-1:0] mem [2**MEMADDRBITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: single-word writes in IDLE, fixed-latency incrementing read bursts.
// Reads are issued in BURST; each beat becomes visible one cycle after its issue.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATABITS    = DEF_DATABITS,
  parameter int unsigned ADDRBITS    = DEF_ADDRBITS,
  parameter int unsigned MEMADDRBITS = DEF_MEMADDRBITS,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDRBITS-1:0]      mem_addr,
  input  logic [DATABITS-1:0]      mem_in,
  output logic [DATABITS-1:0]      mem_out,
  output logic                     mem_out_valid,
  input  logic                     mem_rdreq,
  input  logic                     mem_wrreq,
  input  logic [15:0]              mem_burstlen,
  output logic                     busy,
  output logic                     err_collision
);

  resp_state_e state, state_nxt;

  logic [MEMADDRBITS-1:0]   req_idx;
  logic [MEMADDRBITS-1:0]   cur_idx;
  logic [BURSTLEN_BITS-1:0] beats_left;
  logic [LAT_BITS-1:0]      lat_cnt;
  logic                     valid_q;
  logic                     sram_we;
  logic                     sram_re;
  logic [MEMADDRBITS-1:0]   sram_addr;
  logic                     unused_addr_bits;

  assign req_idx          = mem_addr[MEMADDRBITS+1:2];
  assign unused_addr_bits = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};

  always_comb begin
    state_nxt = state;
    sram_we   = 1'b0;
    sram_re   = 1'b0;
    sram_addr = (state == ST_IDLE) ? req_idx : cur_idx;
    case (state)
      ST_IDLE: begin
        if (mem_wrreq)      sram_we   = 1'b1;
        else if (mem_rdreq) state_nxt = (RD_LATENCY == 1) ? ST_BURST : ST_LAT;
      end
      ST_LAT: begin
        if (lat_cnt == LAT_BITS'(1)) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        sram_re = 1'b1;
        if (beats_left == BURSTLEN_BITS'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!mem_rdreq) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cur_idx       <= '0;
      beats_left    <= '0;
      lat_cnt       <= '0;
      valid_q       <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= (state == ST_BURST);
      if (mem_wrreq && (state != ST_IDLE)) err_collision <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!mem_wrreq && mem_rdreq) begin
            cur_idx    <= req_idx;
            beats_left <= eff_burstlen(mem_burstlen);
            lat_cnt    <= LAT_BITS'(RD_LATENCY - 1);
          end
        end
        ST_LAT:   lat_cnt <= lat_cnt - LAT_BITS'(1);
        ST_BURST: begin
          cur_idx    <= cur_idx + 1'b1;
          beats_left <= beats_left - BURSTLEN_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  resp_sram #(
    .DATABITS    (DATABITS),
    .MEMADDRBITS (MEMADDRBITS)
  ) u_sram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (sram_we),
    .re      (sram_re),
    .addr    (sram_addr),
    .wdata   (mem_in),
    .rdata   (mem_out)
  );

  assign mem_out_valid = valid_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=4.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic [31:0] addr    [2];
  logic [31:0] din     [2];
  logic [31:0] dout    [2];
  logic        valid   [2];
  logic        rdreq   [2];
  logic        wrreq   [2];
  logic [15:0] blen    [2];
  logic        busy    [2];
  logic        err     [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(rst_n[0]), .mem_addr(addr[0]), .mem_in(din[0]),
    .mem_out(dout[0]), .mem_out_valid(valid[0]), .mem_rdreq(rdreq[0]),
    .mem_wrreq(wrreq[0]), .mem_burstlen(blen[0]), .busy(busy[0]),
    .err_collision(err[0])
  );

  mem_responder #(.RD_LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset_n(rst_n[1]), .mem_addr(addr[1]), .mem_in(din[1]),
    .mem_out(dout[1]), .mem_out_valid(valid[1]), .mem_rdreq(rdreq[1]),
    .mem_wrreq(wrreq[1]), .mem_burstlen(blen[1]), .busy(busy[1]),
    .err_collision(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d);
    wrreq[s] = 1'b1;
    addr[s]  = a;
    din[s]   = d;
    @(negedge clk);
    wrreq[s] = 1'b0;
  endtask

  task automatic rd_start(input int s, input logic [31:0] a, input logic [15:0] len);
    rdreq[s] = 1'b1;
    addr[s]  = a;
    blen[s]  = len;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; addr[s] = '0; din[s] = '0;
      rdreq[s] = 1'b0; wrreq[s] = 1'b0; blen[s] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid[0]), 32'd0);
    chk("rst_busy",  32'(busy[0]),  32'd0);
    chk("rst_err",   32'(err[0]),   32'd0);
    chk("rst_out",   dout[0],       32'd0);
    chk("rst_busy4", 32'(busy[1]),  32'd0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // single-beat read, latency 1
    wr(0, 32'h80, 32'h0fff0001);
    rd_start(0, 32'h80, 16'd1);
    rdreq[0] = 1'b0;
    chk("t1_pre_valid", 32'(valid[0]), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(valid[0]), 32'd1);
    chk("t1_data",  dout[0], 32'h0fff0001);
    @(negedge clk);
    chk("t1_post_valid", 32'(valid[0]), 32'd0);
    chk("t1_idle",       32'(busy[0]),  32'd0);

    // eight-beat burst with rdreq held; mid-burst input changes ignored
    for (int i = 0; i < 8; i++) wr(0, 32'h80 + 32'(4*i), 32'h0fff0001 + 32'(i));
    rd_start(0, 32'h80, 16'd8);
    chk("t2_pre_valid", 32'(valid[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) begin addr[0] = 32'h100; blen[0] = 16'd1; end
      chk($sformatf("t2_valid%0d", k), 32'(valid[0]), 32'd1);
      chk($sformatf("t2_data%0d", k),  dout[0], 32'h0fff0001 + 32'(k));
    end
    @(negedge clk);
    chk("t2_end_valid", 32'(valid[0]), 32'd0);
    chk("t2_end_busy",  32'(busy[0]),  32'd1);
    @(negedge clk);
    chk("t2_hold_valid", 32'(valid[0]), 32'd0);
    chk("t2_hold_busy",  32'(busy[0]),  32'd1);
    rdreq[0] = 1'b0;
    @(negedge clk);
    chk("t2_release", 32'(busy[0]), 32'd0);

    // latency 4 with index wrap 511 -> 0
    wr(1, 32'h7fc, 32'ha5a50001);
    wr(1, 32'h000, 32'ha5a50002);
    rd_start(1, 32'h7fc, 16'd2);
    rdreq[1] = 1'b0;
    chk("t3_lat0", 32'(valid[1]), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t3_lat%0d", k), 32'(valid[1]), 32'd0);
    end
    @(negedge clk);
    chk("t3_b0_valid", 32'(valid[1]), 32'd1);
    chk("t3_b0_data",  dout[1], 32'ha5a50001);
    @(negedge clk);
    chk("t3_b1_valid", 32'(valid[1]), 32'd1);
    chk("t3_b1_data",  dout[1], 32'ha5a50002);
    @(negedge clk);
    chk("t3_end_valid", 32'(valid[1]), 32'd0);
    chk("t3_idle",      32'(busy[1]),  32'd0);

    // simultaneous read and write in IDLE: write wins
    rdreq[0] = 1'b1; wrreq[0] = 1'b1; addr[0] = 32'h100; din[0] = 32'h22222222; blen[0] = 16'd1;
    @(negedge clk);
    rdreq[0] = 1'b0; wrreq[0] = 1'b0;
    chk("t4_no_burst", 32'(busy[0]),  32'd0);
    chk("t4_no_valid", 32'(valid[0]), 32'd0);
    rd_start(0, 32'h100, 16'd1);
    rdreq[0] = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(valid[0]), 32'd1);
    chk("t4_data",  dout[0], 32'h22222222);
    @(negedge clk);

    // write during BURST: dropped, sticky collision flag
    chk("t5_err_before", 32'(err[0]), 32'd0);
    rd_start(0, 32'h80, 16'd4);
    rdreq[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wrreq[0] = 1'b1; addr[0] = 32'h80; din[0] = 32'hdeadbeef;
    @(negedge clk);
    wrreq[0] = 1'b0;
    chk("t5_err_set",  32'(err[0]), 32'd1);
    chk("t5_b3_data",  dout[0], 32'h0fff0003);
    repeat (3) @(negedge clk);
    rd_start(0, 32'h80, 16'd1);
    rdreq[0] = 1'b0;
    @(negedge clk);
    chk("t5_mem_kept", dout[0], 32'h0fff0001);
    chk("t5_err_stay", 32'(err[0]), 32'd1);
    @(negedge clk);

    // burstlen 0 behaves as 1
    rd_start(0, 32'h84, 16'd0);
    rdreq[0] = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(valid[0]), 32'd1);
    chk("t6_data",  dout[0], 32'h0fff0002);
    @(negedge clk);
    chk("t6_single", 32'(valid[0]), 32'd0);
    @(negedge clk);

    // reset at beat 3 of an 8-beat burst
    rd_start(0, 32'h80, 16'd8);
    rdreq[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_b3_data", dout[0], 32'h0fff0003);
    rst_n[0] = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(valid[0]), 32'd0);
    chk("t7_rst_busy",  32'(busy[0]),  32'd0);
    chk("t7_rst_err",   32'(err[0]),   32'd0);
    chk("t7_rst_out",   dout[0],       32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t7_quiet%0d", k), 32'(valid[0]), 32'd0);
    end
    chk("t7_idle", 32'(busy[0]), 32'd0);

    // memory survives reset
    rd_start(0, 32'h88, 16'd1);
    rdreq[0] = 1'b0;
    @(negedge clk);
    chk("t8_valid", 32'(valid[0]), 32'd1);
    chk("t8_data",  dout[0], 32'h0fff0003);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
